wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback arbiter and buffer that drives the register file's single write port.
//   Collects results from the ALU and the LSU through valid/ready handshakes and
//   queues them in one shared in-order FIFO.
//   Drains one entry per cycle onto the regfile write interface (wr_en/addr/data).
//   Sits between the execute/memory stages and the regfile.
// PARAMETERS
//   XW     32  data width; matches the regfile XW
//   DEPTH  4   shared FIFO entries; power of 2, >= 2
// PORTS
//   clk            in   1    clock, rising edge
//   rst            in   1    asynchronous reset, active-high
//   lsu_valid_ip   in   1    LSU result valid
//   lsu_ready_op   out  1    LSU result accepted when valid & ready
//   lsu_addr_ip    in   5    LSU destination register
//   lsu_data_ip    in   XW   LSU result data
//   alu_valid_ip   in   1    ALU result valid
//   alu_ready_op   out  1    ALU result accepted when valid & ready
//   alu_addr_ip    in   5    ALU destination register
//   alu_data_ip    in   XW   ALU result data
//   wr_en_op       out  1    regfile write enable
//   wr_addr_op     out  5    regfile write address
//   wr_data_op     out  XW   regfile write data
//   busy_op        out  1    FIFO non-empty or wr_en_op high
//   rs1_addr_ip    in   5    forwarding lookup, source 1
//   rs2_addr_ip    in   5    forwarding lookup, source 2
//   fwd1_hit_op    out  1    pending write matches rs1
//   fwd1_data_op   out  XW   youngest pending data for rs1
//   fwd2_hit_op    out  1    pending write matches rs2
//   fwd2_data_op   out  XW   youngest pending data for rs2
// BEHAVIOUR
// - Reset (async, rst high): FIFO emptied, count = 0, pointers = 0; all outputs 0.
//   This includes wr_en_op, wr_addr_op, wr_data_op, busy_op, both readys and all fwd outputs.
// - Reset mid-operation: all queued results are discarded; no write issues after reset.
// - Readys are registered functions of free = DEPTH - count, with no valid->ready path:
//   - lsu_ready_op = (free >= 1)
//   - alu_ready_op = (free >= 2)
// - Push: when valid & ready, the entry is enqueued at the clock edge.
//   - Simultaneous LSU and ALU pushes: LSU is enqueued first as the older instruction,
//     then ALU; count += 2.
//   - A handshake with addr == 0 completes but nothing is enqueued, since x0 is never written.
// - Pop: at each edge where count (pre-edge) > 0, the head moves into wr_* registers and
//   wr_en_op = 1 for that cycle. Otherwise wr_en_op = 0, and wr_addr/wr_data hold their values.
// - Push and pop in the same edge are allowed: count' = count + pushes - pop.
// - Latency: a push at edge N produces wr_en_op high in the cycle after edge N+1.
//   Throughput is 1 write/cycle.
// - Pointers wrap modulo DEPTH. A full FIFO drops both readys; an empty FIFO raises busy_op
//   only while wr_en_op = 1.
// - Order is preserved: regfile writes appear in exact enqueue order.
// - Pipeline is responsible for holding valid/addr/data stable until ready.
// CONFIGURATION
//   WB_FWD_EN defined:
//   - fwdN_hit_op = (rsN_addr != 0) and the address matches wr_addr_op while wr_en_op = 1,
//     or matches any occupied FIFO entry.
//   - fwdN_data_op = data of the youngest match (FIFO tail side first, wr_* register last).
//   - The lookup is combinational, same cycle.
//   WB_FWD_EN undefined: fwd1/fwd2 hit and data are tied to 0; rs*_addr_ip are unused.
// TESTING
// - Single push: LSU x5=0xDEAD_BEEF at edge 0 -> wr_en=1, addr=5, data=0xDEADBEEF in cycle 1 only.
// - Dual push: LSU x3=0x11 and ALU x3=0x22 in the same cycle.
//   -> two writes to x3 in consecutive cycles, 0x11 then 0x22.
// - Fill: DEPTH=4, hold alu_valid with pushes to x1..x4 each cycle.
//   -> alu_ready=0 once free<2, lsu_ready=0 at count=4, recovery as the FIFO drains,
//      order preserved with no loss.
// - x0 drop: ALU push addr=0 data=0xFF -> ready handshake completes, wr_en never asserted,
//   count unchanged.
// - Reset mid-operation: 3 entries queued, assert rst for 1 cycle.
//   -> wr_en=0, readys=0 during reset, no stale writes afterwards, readys=1 after release.
// - WB_FWD_EN: queued x7=0xA then x7=0xB, rs1=7 -> fwd1_hit=1, data=0xB.
//   rs2=0 -> fwd2_hit=0. Macro undefined -> all fwd outputs 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU results into one in-order FIFO feeding the regfile write port.
// Optional same-cycle forwarding from pending writes is enabled by defining WB_FWD_EN.
module wb_arbiter #(
    parameter int XW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lsu_valid_ip,
    output logic          lsu_ready_op,
    input  logic [4:0]    lsu_addr_ip,
    input  logic [XW-1:0] lsu_data_ip,
    input  logic          alu_valid_ip,
    output logic          alu_ready_op,
    input  logic [4:0]    alu_addr_ip,
    input  logic [XW-1:0] alu_data_ip,
    output logic          wr_en_op,
    output logic [4:0]    wr_addr_op,
    output logic [XW-1:0] wr_data_op,
    output logic          busy_op,
    input  logic [4:0]    rs1_addr_ip,
    input  logic [4:0]    rs2_addr_ip,
    output logic          fwd1_hit_op,
    output logic [XW-1:0] fwd1_data_op,
    output logic          fwd2_hit_op,
    output logic [XW-1:0] fwd2_data_op
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]    addr;
        logic [XW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          lsu_ready_reg, alu_ready_reg;
    logic          wr_en_reg;
    logic [4:0]    wr_addr_reg;
    logic [XW-1:0] wr_data_reg;

    logic          lsu_push, alu_push, pop;
    logic [PW-1:0] alu_wptr;

    // A handshake to x0 still completes, it just never reaches the FIFO.
    assign lsu_push = lsu_valid_ip && lsu_ready_reg && (lsu_addr_ip != 5'd0);
    assign alu_push = alu_valid_ip && alu_ready_reg && (alu_addr_ip != 5'd0);
    assign pop      = (count_reg != '0);
    assign alu_wptr = wptr_reg + PW'(lsu_push);

    always_comb begin
        count_next = count_reg;
        count_next = count_reg + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            lsu_ready_reg <= 1'b0;
            alu_ready_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wptr_reg      <= wptr_reg + PW'(lsu_push) + PW'(alu_push);
            count_reg     <= count_next;
            // ALU needs two free slots so a simultaneous LSU+ALU push always fits.
            lsu_ready_reg <= (count_next <= CW'(DEPTH - 1));
            alu_ready_reg <= (count_next <= CW'(DEPTH - 2));
            wr_en_reg     <= pop;
            if (pop) begin
                rptr_reg    <= rptr_reg + PW'(1);
                wr_addr_reg <= mem[rptr_reg].addr;
                wr_data_reg <= mem[rptr_reg].data;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (lsu_push) mem[wptr_reg] <= '{addr: lsu_addr_ip, data: lsu_data_ip};
        if (alu_push) mem[alu_wptr] <= '{addr: alu_addr_ip, data: alu_data_ip};
    end

    assign lsu_ready_op = lsu_ready_reg;
    assign alu_ready_op = alu_ready_reg;
    assign wr_en_op     = wr_en_reg;
    assign wr_addr_op   = wr_addr_reg;
    assign wr_data_op   = wr_data_reg;
    assign busy_op      = pop || wr_en_reg;

`ifdef WB_FWD_EN
    logic [XW-1:0]    slot_data [DEPTH];
    logic [DEPTH-1:0] hit1_vec, hit2_vec;

    // Slot gi is the gi-th oldest occupied entry counting from the head.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] idx;
        logic          occ;
        assign idx           = rptr_reg + PW'(gi);
        assign occ           = (CW'(gi) < count_reg);
        assign slot_data[gi] = mem[idx].data;
        assign hit1_vec[gi]  = occ && (mem[idx].addr == rs1_addr_ip);
        assign hit2_vec[gi]  = occ && (mem[idx].addr == rs2_addr_ip);
    end

    always_comb begin
        fwd1_hit_op  = 1'b0;
        fwd1_data_op = '0;
        fwd2_hit_op  = 1'b0;
        fwd2_data_op = '0;
        if (wr_en_reg && (wr_addr_reg == rs1_addr_ip)) begin
            fwd1_hit_op  = 1'b1;
            fwd1_data_op = wr_data_reg;
        end
        if (wr_en_reg && (wr_addr_reg == rs2_addr_ip)) begin
            fwd2_hit_op  = 1'b1;
            fwd2_data_op = wr_data_reg;
        end
        // Later (younger) slots override older ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (hit1_vec[i]) begin
                fwd1_hit_op  = 1'b1;
                fwd1_data_op = slot_data[i];
            end
            if (hit2_vec[i]) begin
                fwd2_hit_op  = 1'b1;
                fwd2_data_op = slot_data[i];
            end
        end
        if (rs1_addr_ip == 5'd0) begin
            fwd1_hit_op  = 1'b0;
            fwd1_data_op = '0;
        end
        if (rs2_addr_ip == 5'd0) begin
            fwd2_hit_op  = 1'b0;
            fwd2_data_op = '0;
        end
    end
`else
    logic unused_rs;
    assign unused_rs    = ^{rs1_addr_ip, rs2_addr_ip};
    assign fwd1_hit_op  = 1'b0;
    assign fwd1_data_op = '0;
    assign fwd2_hit_op  = 1'b0;
    assign fwd2_data_op = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: every accepted non-x0 push is queued and checked against regfile writes.
module tb_wb_arbiter;
    localparam int XW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lsu_valid = 1'b0, alu_valid = 1'b0;
    logic          lsu_ready, alu_ready;
    logic [4:0]    lsu_addr = '0, alu_addr = '0;
    logic [XW-1:0] lsu_data = '0, alu_data = '0;
    logic          wr_en, busy;
    logic [4:0]    wr_addr;
    logic [XW-1:0] wr_data;
    logic [4:0]    rs1_addr = '0, rs2_addr = '0;
    logic          fwd1_hit, fwd2_hit;
    logic [XW-1:0] fwd1_data, fwd2_data;

    always #5 clk = ~clk;

    wb_arbiter #(.XW(XW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid_ip(lsu_valid), .lsu_ready_op(lsu_ready),
        .lsu_addr_ip(lsu_addr), .lsu_data_ip(lsu_data),
        .alu_valid_ip(alu_valid), .alu_ready_op(alu_ready),
        .alu_addr_ip(alu_addr), .alu_data_ip(alu_data),
        .wr_en_op(wr_en), .wr_addr_op(wr_addr), .wr_data_op(wr_data),
        .busy_op(busy),
        .rs1_addr_ip(rs1_addr), .rs2_addr_ip(rs2_addr),
        .fwd1_hit_op(fwd1_hit), .fwd1_data_op(fwd1_data),
        .fwd2_hit_op(fwd2_hit), .fwd2_data_op(fwd2_data)
    );

    typedef struct packed {
        logic [4:0]    addr;
        logic [XW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0, failures = 0;
    int  mcount = 0;
    int  mon_n;
    bit  pop_pending = 0, rdy_zero = 1, alu_stall_seen = 0;
    bit  exp_lsu_rdy, exp_alu_rdy, exp_busy;

    // Scoreboard/model: checks writes, readys and busy every cycle, queues accepted pushes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcount      = 0;
            pop_pending = 0;
            rdy_zero    = 1;
        end else begin
            checks++;
            if (wr_en !== pop_pending) begin
                failures++;
                $display("FAIL sb_wr_en got=%0b exp=%0b t=%0t", wr_en, pop_pending, $time);
            end
            if (wr_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write got x%0d=0x%08h exp=none t=%0t", wr_addr, wr_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== mon_e) begin
                        failures++;
                        $display("FAIL sb_write got x%0d=0x%08h exp x%0d=0x%08h t=%0t",
                                 wr_addr, wr_data, mon_e.addr, mon_e.data, $time);
                    end else begin
                        $display("write x%0d = 0x%08h t=%0t", wr_addr, wr_data, $time);
                    end
                end
            end
            exp_lsu_rdy = rdy_zero ? 1'b0 : (mcount <= DEPTH - 1);
            exp_alu_rdy = rdy_zero ? 1'b0 : (mcount <= DEPTH - 2);
            exp_busy    = (mcount != 0) || pop_pending;
            checks++;
            if ({lsu_ready, alu_ready} !== {exp_lsu_rdy, exp_alu_rdy}) begin
                failures++;
                $display("FAIL sb_readys got lsu=%0b alu=%0b exp lsu=%0b alu=%0b t=%0t",
                         lsu_ready, alu_ready, exp_lsu_rdy, exp_alu_rdy, $time);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL sb_busy got=%0b exp=%0b t=%0t", busy, exp_busy, $time);
            end
            if (alu_valid && !alu_ready) alu_stall_seen = 1;
            mon_n = 0;
            if (lsu_valid && lsu_ready && lsu_addr != 5'd0) begin
                exp_q.push_back('{addr: lsu_addr, data: lsu_data});
                mon_n++;
            end
            if (alu_valid && alu_ready && alu_addr != 5'd0) begin
                exp_q.push_back('{addr: alu_addr, data: alu_data});
                mon_n++;
            end
            pop_pending = (mcount > 0);
            mcount      = mcount + mon_n - (pop_pending ? 1 : 0);
            rdy_zero    = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout got busy=%0b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, busy} !== '0) begin
            failures++;
            $display("FAIL reset_wr got en=%0b x%0d=0x%08h busy=%0b exp all 0", wr_en, wr_addr, wr_data, busy);
        end
        checks++;
        if ({lsu_ready, alu_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_readys got %b exp 00", {lsu_ready, alu_ready});
        end
        checks++;
        if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== '0) begin
            failures++;
            $display("FAIL reset_fwd got hit1=%0b hit2=%0b exp 0", fwd1_hit, fwd2_hit);
        end
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({lsu_ready, alu_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_readys got %b exp 11", {lsu_ready, alu_ready});
        end
    endtask

    task automatic test_single_push();
        step();
        lsu_valid = 1'b1; lsu_addr = 5'd5; lsu_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle0 got wr_en=%0b exp 0", wr_en);
        end
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_cycle1 got en=%0b x%0d=0x%08h exp en=1 x5=0xdeadbeef", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_cycle2_hold got en=%0b x%0d=0x%08h exp en=0 x5=0xdeadbeef", wr_en, wr_addr, wr_data);
        end
        wait_idle();
    endtask

    task automatic test_dual_push();
        step();
        lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h22;
        @(posedge clk); #1;
        lsu_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h11}) begin
            failures++;
            $display("FAIL dual_first got en=%0b x%0d=0x%08h exp en=1 x3=0x11", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h22}) begin
            failures++;
            $display("FAIL dual_second got en=%0b x%0d=0x%08h exp en=1 x3=0x22", wr_en, wr_addr, wr_data);
        end
        wait_idle();
    endtask

    task automatic lsu_stream();
        bit fired;
        step();
        for (int k = 1; k <= 4; k++) begin
            lsu_valid = 1'b1; lsu_addr = 5'(8 + k); lsu_data = 32'h1000 + k;
            fired = 0;
            for (int t = 0; t < 20 && !fired; t++) begin
                @(negedge clk);
                fired = lsu_ready;
                @(posedge clk); #1;
            end
            if (!fired) begin
                failures++;
                $display("FAIL fill_lsu_timeout got ready=0 exp 1");
            end
        end
        lsu_valid = 1'b0;
    endtask

    task automatic alu_stream();
        bit fired;
        step();
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1; alu_addr = 5'(k); alu_data = 32'h2000 + k;
            fired = 0;
            for (int t = 0; t < 20 && !fired; t++) begin
                @(negedge clk);
                fired = alu_ready;
                @(posedge clk); #1;
            end
            if (!fired) begin
                failures++;
                $display("FAIL fill_alu_timeout got ready=0 exp 1");
            end
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_fill();
        alu_stall_seen = 0;
        fork
            lsu_stream();
            alu_stream();
        join
        wait_idle();
        checks++;
        if (alu_stall_seen !== 1'b1) begin
            failures++;
            $display("FAIL fill_alu_stall got stall_seen=%0b exp 1", alu_stall_seen);
        end
        checks++;
        if ({lsu_ready, alu_ready} !== 2'b11) begin
            failures++;
            $display("FAIL fill_recovery got %b exp 11", {lsu_ready, alu_ready});
        end
    endtask

    task automatic test_x0_drop();
        int seen = 0;
        step();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_handshake got ready=%0b exp 1", alu_ready);
        end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL x0_no_write got active_cycles=%0d exp 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        step();
        lsu_valid = 1'b1; lsu_addr = 5'd9;  lsu_data = 32'h900;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA00;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        lsu_addr = 5'd11; lsu_data = 32'hB00;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_en, busy, lsu_ready, alu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async got en=%0b busy=%0b rdy=%b%b exp all 0", wr_en, busy, lsu_ready, alu_ready);
        end
        @(negedge clk);
        checks++;
        if ({wr_en, busy, lsu_ready, alu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_held got en=%0b busy=%0b rdy=%b%b exp all 0", wr_en, busy, lsu_ready, alu_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rstmid_stale got writes=%0d exp 0", seen);
        end
        checks++;
        if ({lsu_ready, alu_ready} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_readys got %b exp 11", {lsu_ready, alu_ready});
        end
    endtask

    task automatic test_back_to_back();
        int total = 0, run = 0, max_run = 0;
        step();
        for (int k = 0; k < 8; k++) begin
            lsu_valid = 1'b1;
            lsu_addr  = 5'($urandom_range(1, 31));
            lsu_data  = $urandom;
            @(negedge clk);
            if (wr_en === 1'b1) begin total++; run++; if (run > max_run) max_run = run; end
            else run = 0;
            @(posedge clk); #1;
        end
        lsu_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin total++; run++; if (run > max_run) max_run = run; end
            else run = 0;
        end
        checks++;
        if (total != 8 || max_run != 8) begin
            failures++;
            $display("FAIL b2b_throughput got writes=%0d run=%0d exp 8/8", total, max_run);
        end
        wait_idle();
    endtask

    task automatic test_forward();
        bit            exp_hit;
        logic [XW-1:0] exp_dat;
`ifdef WB_FWD_EN
        exp_hit = 1'b1; exp_dat = 32'hB;
`else
        exp_hit = 1'b0; exp_dat = 32'h0;
`endif
        step();
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hA;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hB;
        @(posedge clk); #1;
        lsu_valid = 1'b0; alu_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({fwd1_hit, fwd1_data} !== {exp_hit, exp_dat}) begin
                failures++;
                $display("FAIL fwd1_c%0d got hit=%0b data=0x%0h exp hit=%0b data=0x%0h", c, fwd1_hit, fwd1_data, exp_hit, exp_dat);
            end
            checks++;
            if ({fwd2_hit, fwd2_data} !== '0) begin
                failures++;
                $display("FAIL fwd2_x0_c%0d got hit=%0b data=0x%0h exp 0", c, fwd2_hit, fwd2_data);
            end
        end
        @(negedge clk);
        checks++;
        if (fwd1_hit !== 1'b0) begin
            failures++;
            $display("FAIL fwd1_drained got hit=%0b exp 0", fwd1_hit);
        end
        rs1_addr = '0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_dual_push();
        test_fill();
        test_x0_drop();
        test_reset_mid();
        test_back_to_back();
        test_forward();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got pending=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
